// File: rtl/sar_multich.sv
// Multi-channel SAR ADC controller: sweeps the masked channels, one successive-approximation conversion per channel.
// Optional macro SAR_AVG4_EN: four conversions per channel, reporting the truncated mean.
module sar_multich #(
  parameter int Width        = 10,
  parameter int Channels     = 4,
  parameter int SampleCycles = 2,
  localparam int ChW         = (Channels > 1) ? $clog2(Channels) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [Channels-1:0] ch_mask_i,
  input  logic                continuous_i,
  input  logic                cmp_i,
  output logic [Width-1:0]    dac_o,
  output logic                sample_o,
  output logic [ChW-1:0]      ch_sel_o,
  output logic [Width-1:0]    result_o,
  output logic [ChW-1:0]      result_ch_o,
  output logic                valid_o,
  output logic                eoc_o,
  output logic                busy_o
);

  localparam int KW = $clog2(Width);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  state_t              state;
  logic [Channels-1:0] mask_q;
  logic [ChW-1:0]      ch_q;
  logic [3:0]          cnt;
  logic [KW-1:0]       k;
  logic [Width-1:0]    acc;
  logic [Width-1:0]    result_q;
  logic [ChW-1:0]      result_ch_q;
  logic                valid_q;

  logic [Width-1:0]    bit_k;
  logic [Width-1:0]    acc_next;
  logic                has_next;
  logic [ChW-1:0]      next_ch;
  logic [ChW-1:0]      first_ch;
  logic [ChW-1:0]      start_ch;

`ifdef SAR_AVG4_EN
  logic [Width+1:0]    sum;
  logic [1:0]          avg;
  logic [Width+1:0]    sum_next;
  assign sum_next = sum + {2'b00, acc_next};
`endif

  assign bit_k    = Width'(1) << k;
  assign acc_next = acc | (cmp_i ? bit_k : '0);

  // Descending scan so the lowest qualifying channel wins.
  always_comb begin
    has_next = 1'b0;
    next_ch  = ch_q;
    first_ch = '0;
    start_ch = '0;
    for (int unsigned i = Channels; i > 0; i--) begin
      if (mask_q[i-1] && ((i - 1) > 32'(ch_q))) begin
        next_ch  = ChW'(i - 1);
        has_next = 1'b1;
      end
      if (mask_q[i-1])    first_ch = ChW'(i - 1);
      if (ch_mask_i[i-1]) start_ch = ChW'(i - 1);
    end
  end

  always_comb begin
    case (state)
      CONVERT: dac_o = acc | bit_k;
      DONE:    dac_o = acc;
      default: dac_o = '0;
    endcase
  end

  assign sample_o    = (state == SAMPLE);
  assign busy_o      = (state != IDLE);
  assign ch_sel_o    = ch_q;
  assign result_o    = result_q;
  assign result_ch_o = result_ch_q;
  assign valid_o     = valid_q;
  assign eoc_o       = valid_q && !has_next && !continuous_i && !abort_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      mask_q      <= '0;
      ch_q        <= '0;
      cnt         <= '0;
      k           <= '0;
      acc         <= '0;
      result_q    <= '0;
      result_ch_q <= '0;
      valid_q     <= 1'b0;
`ifdef SAR_AVG4_EN
      sum         <= '0;
      avg         <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (abort_i && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
`ifdef SAR_AVG4_EN
            sum <= '0;
            avg <= '0;
`endif
            if (start_i && |ch_mask_i) begin
              mask_q <= ch_mask_i;
              ch_q   <= start_ch;
              cnt    <= '0;
              state  <= SAMPLE;
            end
          end
          SAMPLE: begin
            if (cnt == 4'(SampleCycles - 1)) begin
              k     <= KW'(Width - 1);
              acc   <= '0;
              state <= CONVERT;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          CONVERT: begin
            acc <= acc_next;
            if (k == '0) begin
`ifdef SAR_AVG4_EN
              if (avg == 2'd3) begin
                result_q    <= Width'(sum_next >> 2);
                result_ch_q <= ch_q;
                valid_q     <= 1'b1;
                sum         <= '0;
                avg         <= '0;
                state       <= DONE;
              end else begin
                sum   <= sum_next;
                avg   <= avg + 2'd1;
                cnt   <= '0;
                state <= SAMPLE;
              end
`else
              result_q    <= acc_next;
              result_ch_q <= ch_q;
              valid_q     <= 1'b1;
              state       <= DONE;
`endif
            end else begin
              k <= k - KW'(1);
            end
          end
          DONE: begin
            cnt <= '0;
            if (has_next) begin
              ch_q  <= next_ch;
              state <= SAMPLE;
            end else if (continuous_i) begin
              ch_q  <= first_ch;
              state <= SAMPLE;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sar_multich.sv
// Bench for sar_multich: ideal comparator model, table-driven sweeps checked through a result scoreboard.
module tb_sar_multich;

  localparam int W = 10;
  localparam int N = 4;
  localparam int S = 2;
`ifdef SAR_AVG4_EN
  localparam int LAT = 4 * (S + W) + 1;
`else
  localparam int LAT = S + W + 1;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic [N-1:0] ch_mask_i = '0;
  logic         continuous_i = 1'b0;
  logic         cmp_i;
  logic [W-1:0] dac_o;
  logic         sample_o;
  logic [1:0]   ch_sel_o;
  logic [W-1:0] result_o;
  logic [1:0]   result_ch_o;
  logic         valid_o;
  logic         eoc_o;
  logic         busy_o;

  logic [W-1:0] vin [N];

  sar_multich #(.Width(W), .Channels(N), .SampleCycles(S)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .ch_mask_i(ch_mask_i), .continuous_i(continuous_i), .cmp_i(cmp_i),
    .dac_o(dac_o), .sample_o(sample_o), .ch_sel_o(ch_sel_o), .result_o(result_o),
    .result_ch_o(result_ch_o), .valid_o(valid_o), .eoc_o(eoc_o), .busy_o(busy_o)
  );

  assign cmp_i = (vin[ch_sel_o] >= dac_o);

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] res;
    logic [1:0]   ch;
    logic         eoc;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [N-1:0]        mask;
    logic [N-1:0][W-1:0] v;
  } vec_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           pops = 0;
  logic [W-1:0] last_res = '0;

  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result %0h ch %0d expected no valid", result_o, result_ch_o);
      end else begin
        e = sb.pop_front();
        check("result", result_o, e.res);
        check("result_ch", result_ch_o, e.ch);
        check("eoc", eoc_o, e.eoc);
        check("latency", cyc, e.cyc);
        last_res = e.res;
        pops++;
      end
    end else begin
      if (eoc_o === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL stray_eoc: got 1 expected 0 (cycle %0d)", cyc);
      end
      if (rst_ni === 1'b1) check("result_hold", result_o, last_res);
    end
  end

  // Drive one start and push the results expected from `sweeps` sweeps.
  task automatic launch(input logic [N-1:0] mask, input int sweeps);
    int base;
    int n;
    int total;
    n = 0;
    total = $countones(mask) * sweeps;
    @(negedge clk_i);
    ch_mask_i = mask;
    start_i = 1'b1;
    base = cyc + 1;
    for (int s = 0; s < sweeps; s++)
      for (int c = 0; c < N; c++)
        if (mask[c]) begin
          sb.push_back('{res: vin[c], ch: 2'(c), eoc: (n == total - 1), cyc: base + LAT - 1 + LAT * n});
          n++;
        end
    @(negedge clk_i);
    start_i = 1'b0;
    ch_mask_i = '1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check(name, busy_o, 1'b0);
    check("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    vec_t         tbl[6];
    logic [W-1:0] ones;
    logic [W-1:0] ex;
    int           p0;
    int           n;

    tbl[0] = '{mask: 4'b0101, v: {10'h000, 10'h155, 10'h000, 10'h2AA}};
    tbl[1] = '{mask: 4'b1000, v: {10'h000, 10'h000, 10'h000, 10'h000}};
    tbl[2] = '{mask: 4'b1000, v: {10'h3FF, 10'h000, 10'h000, 10'h000}};
    tbl[3] = '{mask: 4'b1111, v: {10'h3FE, 10'h1FF, 10'h200, 10'h001}};
    tbl[4] = '{mask: 4'b0110, v: {10'h000, 10'h3C3, 10'h123, 10'h000}};
    tbl[5] = '{mask: 4'b0001, v: {10'h000, 10'h000, 10'h000, 10'h200}};
    for (int c = 0; c < N; c++) vin[c] = '0;

    repeat (3) @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_dac", dac_o, 0);
    check("rst_sample", sample_o, 0);
    check("rst_ch_sel", ch_sel_o, 0);
    check("rst_result", result_o, 0);
    check("rst_result_ch", result_ch_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_eoc", eoc_o, 0);
    rst_ni = 1'b1;

    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < N; c++) vin[c] = tbl[i].v[c];
      launch(tbl[i].mask, 1);
      wait_idle("table_idle");
    end

    // DAC trial codes for full scale on ch3
    vin[3] = 10'h3FF;
    ones = '1;
    launch(4'b1000, 1);
    check("sample_1", sample_o, 1);
    check("sample_dac", dac_o, 0);
    check("sample_ch_sel", ch_sel_o, 3);
    @(negedge clk_i);
    check("sample_2", sample_o, 1);
    for (int j = 0; j < W; j++) begin
      @(negedge clk_i);
      ex = ones << (W - 1 - j);
      check("dac_seq", dac_o, ex);
      check("convert_no_sample", sample_o, 0);
    end
    wait_idle("dac_seq_idle");

    // Continuous: three sweeps, drop continuous before the last DONE
    vin[0] = 10'h0F0;
    vin[1] = 10'h30F;
    continuous_i = 1'b1;
    p0 = pops;
    launch(4'b0011, 3);
    n = 0;
    while (pops < p0 + 5 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("continuous_progress", (pops >= p0 + 5), 1);
    continuous_i = 1'b0;
    wait_idle("continuous_idle");

    // Abort at CONVERT bit 5
    vin[0] = 10'h155;
    launch(4'b0001, 0);
    repeat (6) @(negedge clk_i);
    check("abort_point_dac", dac_o, 10'h160);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_result", result_o, last_res);
    repeat (20) @(negedge clk_i);
    check("abort_stays_idle", busy_o, 0);

    // Reset at CONVERT bit 5
    launch(4'b0001, 0);
    repeat (6) @(negedge clk_i);
    check("reset_point_dac", dac_o, 10'h160);
    rst_ni = 1'b0;
    last_res = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    check("midrst_busy", busy_o, 0);
    check("midrst_result", result_o, 0);
    check("midrst_ch_sel", ch_sel_o, 0);
    check("midrst_dac", dac_o, 0);
    repeat (20) @(negedge clk_i);
    check("midrst_stays_idle", busy_o, 0);

    // Zero-mask start is ignored
    @(negedge clk_i);
    ch_mask_i = '0;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check("zero_mask_busy", busy_o, 0);
    repeat (3) @(negedge clk_i);
    check("zero_mask_stays_idle", busy_o, 0);

    // Start while busy is ignored
    vin[2] = 10'h0AB;
    launch(4'b0100, 1);
    repeat (5) @(negedge clk_i);
    ch_mask_i = 4'b1111;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_idle("busy_start_idle");
    repeat (20) @(negedge clk_i);
    check("no_extra_sweep", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sar_multich.md
SAR_MULTICH -- requirements
Module: sar_multich

Interface
REQ-001 Width, default 10: SAR resolution in bits, range 2..16, SHALL be a parameter.
REQ-002 Channels, default 4: number of analog channels, range 1..16, SHALL be a parameter; ChW = max(1, clog2(Channels)).
REQ-003 SampleCycles, default 2: sample-phase length in clocks, range 1..15, SHALL be a parameter.
REQ-004 Ports SHALL be as follows, clock and reset first:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- start_i  in  1  start a sweep; acted on only in IDLE.
- abort_i  in  1  abandon the sweep.
- ch_mask_i  in  Channels  channels to convert; latched at start.
- continuous_i  in  1  repeat the sweep while high.
- cmp_i  in  1  comparator output: 1 = Vin >= Vdac.
- dac_o  out  Width  DAC trial code.
- sample_o  out  1  S/H sample enable.
- ch_sel_o  out  ChW  analog mux select.
- result_o  out  Width  last converted code.
- result_ch_o  out  ChW  channel of result_o.
- valid_o  out  1  result strobe, one cycle.
- eoc_o  out  1  end-of-sweep strobe, one cycle.
- busy_o  out  1  high when not in IDLE.

Function
REQ-005 FSM states SHALL be IDLE, SAMPLE, CONVERT and DONE; busy_o = (state != IDLE).
REQ-006 IDLE, start_i=1 and ch_mask_i != 0: latch the mask, select its lowest set channel, go to SAMPLE. Start with a zero mask SHALL be ignored.
REQ-007 SAMPLE: sample_o=1 and dac_o=0 for exactly SampleCycles clocks, then go to CONVERT with bit index k=Width-1 and accumulator acc=0.
REQ-008 CONVERT: dac_o = acc | (1<<k) combinationally; at each rising edge, bit k of acc takes the value of cmp_i and k decrements; after k=0, go to DONE. Duration SHALL be exactly Width clocks.
REQ-009 DONE (one clock): result_o=acc, result_ch_o=current channel, valid_o=1, dac_o=acc.
REQ-010 Transitions out of DONE:
- If a higher set bit exists in the latched mask, go to SAMPLE on that channel.
- Else, if continuous_i=1, go to SAMPLE on the lowest set channel.
- Else, eoc_o=1 in the same DONE cycle and go to IDLE.
REQ-011 Per-channel latency SHALL be SampleCycles+Width+1 clocks, with no idle gap between channels.
REQ-012 start_i while busy_o=1 SHALL be ignored; ch_mask_i changes while busy SHALL be ignored.
REQ-013 abort_i=1 in any non-IDLE state SHALL force IDLE at the next edge, with no valid_o and no eoc_o. abort_i has priority over every transition.
REQ-014 ch_sel_o SHALL hold the current channel from SAMPLE through DONE and hold its last value in IDLE.
REQ-015 result_o and result_ch_o SHALL change only in DONE and hold otherwise.
REQ-016 With Channels=1, ch_sel_o and result_ch_o SHALL be constant 0.

Reset
REQ-017 rst_ni=0 at a rising edge SHALL force IDLE, including mid-conversion, with no strobe.
REQ-018 Reset values SHALL be: dac_o=0, sample_o=0, ch_sel_o=0, result_o=0, result_ch_o=0, valid_o=0, eoc_o=0, busy_o=0, latched mask=0.

Configuration
REQ-019 Macro SAR_AVG4_EN, when defined, SHALL make each channel convert 4 consecutive times (SAMPLE+CONVERT each) into a Width+2-bit sum, and DONE SHALL output sum>>2 (truncating).
REQ-020 With SAR_AVG4_EN, per-channel latency SHALL be 4*(SampleCycles+Width)+1 clocks, with valid_o pulsed only after the 4th conversion.
REQ-021 Without SAR_AVG4_EN, no sum register exists and behaviour SHALL be exactly REQ-005..REQ-016.

Verification (Width=10, Channels=4, SampleCycles=2, comparator model cmp_i = (vin >= dac_o))
REQ-022 mask=4'b0101, vin ch0=0x2AA, ch2=0x155, continuous=0 -> valid_o 13 clocks after start accepted with result 0x2AA/ch0; again 13 clocks later with 0x155/ch2 and eoc_o in the same cycle; busy_o low next clock.
REQ-023 vin=0x000 and vin=0x3FF on ch3, mask=4'b1000 -> results 0x000 and 0x3FF; dac_o sequence for 0x3FF is 0x200, 0x300, ... 0x3FF.
REQ-024 mask=4'b0011, continuous_i=1 for 3 sweeps then dropped -> ch order 0,1,0,1,0,1; eoc_o only after the sweep in which continuous_i was low at DONE.
REQ-025 abort_i at CONVERT bit 5; separately rst_ni=0 at the same point -> IDLE next clock, no valid_o/eoc_o, result_o unchanged (0 after reset).
REQ-026 start_i with mask=0, and start_i pulsed while busy -> no state change, no extra sweep.
REQ-027 SAR_AVG4_EN defined, vin=0x155 -> single valid_o after 49 clocks with result 0x155.
